// File: rtl/conv_pkg.sv
// Shared definitions for the conv post-processing slice: default datapath
// widths, frame dimension / pixel-count widths and the sequencing FSM states.
package conv_pkg;

    localparam int ACC_WIDTH_DEF   = 32;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int SHIFT_WIDTH_DEF = 5;
    localparam int DIM_WIDTH       = 9;    // feature-map width / height
    localparam int CNT_WIDTH       = 18;   // holds 511*511 pixels

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/requant_sat.sv
// Three-stage requantisation datapath: bias add, round-half-up arithmetic
// right shift, then ReLU/saturation to DATA_WIDTH. A valid bit and a
// first-beat tag travel alongside the data through each stage.
// Macro CONV_POSTPROC_RELU_EN selects unsigned ReLU clamping instead of
// signed saturation.
module requant_sat
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [ACC_WIDTH-1:0]   bias,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [ACC_WIDTH-1:0]   beat,
    input  logic                   beat_valid,
    input  logic                   beat_first,
    output logic                   pix_start,
    output logic [DATA_WIDTH-1:0]  pix_data,
    output logic                   pix_valid,
    output logic                   clamp,      // pixel leaving stage 2 saturates
    output logic                   pend,       // a pixel moves to the output next edge
    output logic                   busy
);

    // One extra bit for the bias sum, one more so the rounding add cannot wrap.
    localparam int SW2 = ACC_WIDTH + 2;

`ifdef CONV_POSTPROC_RELU_EN
    localparam logic signed [SW2-1:0] HI_LIM = {{(SW2-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
    localparam logic signed [SW2-1:0] LO_LIM = '0;
`else
    localparam logic signed [SW2-1:0] HI_LIM = {{(SW2-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW2-1:0] LO_LIM = {{(SW2-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    logic signed [ACC_WIDTH:0] s1;
    logic signed [SW2-1:0]     s2, s2_next, sum;
    logic [SW2-1:0]            rnd;
    logic                      v1, f1, v2, f2;
    logic                      clamp_hi, clamp_lo;
    logic [DATA_WIDTH-1:0]     sat_val;

    // Round half up: add 2^(S-1) before the arithmetic shift (nothing for S==0).
    always_comb begin
        rnd     = ({{(SW2-1){1'b0}}, 1'b1} << shift) >> 1;
        sum     = {s1[ACC_WIDTH], s1} + rnd;
        s2_next = sum >>> shift;
    end

    // Clamp the stage-2 value to the output range.
    always_comb begin
        clamp_hi = s2 > HI_LIM;
        clamp_lo = s2 < LO_LIM;
        if (clamp_hi)
            sat_val = HI_LIM[DATA_WIDTH-1:0];
        else if (clamp_lo)
            sat_val = LO_LIM[DATA_WIDTH-1:0];
        else
            sat_val = s2[DATA_WIDTH-1:0];
    end

`ifdef CONV_POSTPROC_RELU_EN
    // Negative values are ReLU'd to zero, which is not an overflow.
    assign clamp = v2 & clamp_hi;
`else
    assign clamp = v2 & (clamp_hi | clamp_lo);
`endif

    assign pix_start = v2 & f2;
    assign pend      = v2;
    assign busy      = v1 | v2;

    // Pipeline registers; data only loads when its stage carries a beat.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            v1        <= 1'b0;
            f1        <= 1'b0;
            s1        <= '0;
            v2        <= 1'b0;
            f2        <= 1'b0;
            s2        <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            v1 <= beat_valid;
            f1 <= beat_valid & beat_first;
            if (beat_valid)
                s1 <= {beat[ACC_WIDTH-1], beat} + {bias[ACC_WIDTH-1], bias};
            v2 <= v1;
            f2 <= v1 & f1;
            if (v1)
                s2 <= s2_next;
            pix_valid <= v2;
            if (v2)
                pix_data <= sat_val;
        end
    end

endmodule

// File: rtl/conv_postproc.sv
// Post-processing between the conv2d accumulator and maxpool2d: frames a
// raster of accumulator sums, sequences it through requant_sat and produces
// the o_start / o_valid / o_done framing plus a sticky per-frame overflow.
// Macro CONV_POSTPROC_RELU_EN (in requant_sat) selects unsigned ReLU output.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for i_start; parameters latched on accept
//   ST_RUN   | accepting i_valid beats until N have entered the pipeline
//   ST_DRAIN | inputs ignored; wait for pipeline empty, then pulse o_done
module conv_postproc
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [DIM_WIDTH-1:0]   i_max_width,
    input  logic [DIM_WIDTH-1:0]   i_max_height,
    input  logic [ACC_WIDTH-1:0]   i_bias,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    input  logic [ACC_WIDTH-1:0]   i_acc,
    input  logic                   i_valid,
    output logic                   o_start,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    output logic                   o_done,
    output logic                   o_overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   in_cnt, out_cnt, n_pix, dim_prod;
    logic [ACC_WIDTH-1:0]   bias_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic                   start_ok, beat_valid, beat_first, done_nxt;
    logic                   clamp, pend, busy;

    assign dim_prod   = {{(CNT_WIDTH-DIM_WIDTH){1'b0}}, i_max_width}
                      * {{(CNT_WIDTH-DIM_WIDTH){1'b0}}, i_max_height};
    assign start_ok   = (state == ST_IDLE) && i_start;
    assign beat_valid = (state == ST_RUN) && i_valid;
    assign beat_first = (in_cnt == '0);

    // Next-state and o_done decode.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start)
                    state_nxt = (i_max_width == '0 || i_max_height == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (i_valid && in_cnt == n_pix - CNT_ONE)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_cnt == n_pix && !busy) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, frame parameters, pixel counters and the sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            in_cnt     <= '0;
            out_cnt    <= '0;
            n_pix      <= '0;
            bias_q     <= '0;
            shift_q    <= '0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= done_nxt;
            if (start_ok) begin
                n_pix      <= dim_prod;
                bias_q     <= i_bias;
                shift_q    <= i_shift;
                in_cnt     <= '0;
                out_cnt    <= '0;
                o_overflow <= 1'b0;
            end else begin
                if (beat_valid)
                    in_cnt <= in_cnt + CNT_ONE;
                if (pend)
                    out_cnt <= out_cnt + CNT_ONE;
                if (clamp)
                    o_overflow <= 1'b1;
            end
        end
    end

    requant_sat #(
        .ACC_WIDTH   (ACC_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .bias       (bias_q),
        .shift      (shift_q),
        .beat       (i_acc),
        .beat_valid (beat_valid),
        .beat_first (beat_first),
        .pix_start  (o_start),
        .pix_data   (o_data),
        .pix_valid  (o_valid),
        .clamp      (clamp),
        .pend       (pend),
        .busy       (busy)
    );

endmodule

// File: tb/tb_conv_postproc.sv
// Bench for conv_postproc: a frame-level model predicts, per clock cycle,
// o_valid/o_data/o_start/o_done from the arithmetic rules; a compare process
// checks them every cycle, and literal expectations pin the model.
module tb_conv_postproc;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_valid;
    logic [8:0]  i_max_width, i_max_height;
    logic [31:0] i_bias, i_acc;
    logic [4:0]  i_shift;
    logic        o_start, o_valid, o_done, o_overflow;
    logic [15:0] o_data;

    always #5 clk = ~clk;

    conv_postproc dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_max_width  (i_max_width),
        .i_max_height (i_max_height),
        .i_bias       (i_bias),
        .i_shift      (i_shift),
        .i_acc        (i_acc),
        .i_valid      (i_valid),
        .o_start      (o_start),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_done       (o_done),
        .o_overflow   (o_overflow)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        exp_v  [MAXC];
    logic [15:0] exp_d  [MAXC];
    logic        exp_s  [MAXC];
    logic        exp_dn [MAXC];

    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [15:0] cap_q[$];

    // frame-level model state
    bit     active = 1'b0;
    int     act_from = 0;
    int     done_cyc = 0;
    int     fn = 0;
    int     sent = 0;
    longint fbias = 0;
    int     fs = 0;

    function automatic logic [15:0] model(longint acc, longint bias, int s);
        longint v;
        v = acc + bias;
        if (s > 0)
            v = (v + (longint'(1) << (s - 1))) >>> s;
`ifdef CONV_POSTPROC_RELU_EN
        if (v < 0) return 16'h0000;
        if (v > 65535) return 16'hFFFF;
`else
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit st, input bit vl, input logic [31:0] acc,
                         input int w = 0, input int h = 0,
                         input logic [31:0] bias = 0, input int s = 0);
        int c;
        @(posedge clk);
        #1;
        i_start      = st;
        i_valid      = vl;
        i_acc        = acc;
        i_max_width  = 9'(w);
        i_max_height = 9'(h);
        i_bias       = bias;
        i_shift      = 5'(s);
        c = cyc;
        if (vl && active && c >= act_from && sent < fn) begin
            exp_v[c+3] = 1'b1;
            exp_d[c+3] = model($signed(acc), fbias, fs);
            if (sent == 0) exp_s[c+2] = 1'b1;
            sent++;
            if (sent == fn) begin
                active   = 1'b0;
                done_cyc = c + 4;
                exp_dn[c+4] = 1'b1;
            end
        end
        if (st && !active && c >= done_cyc) begin
            fn    = w * h;
            fbias = longint'($signed(bias));
            fs    = s;
            sent  = 0;
            if (fn == 0) begin
                done_cyc = c + 2;
                exp_dn[c+2] = 1'b1;
            end else begin
                active   = 1'b1;
                act_from = c + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_o_start"},    o_start,    0);
        check({tag, "_o_data"},     o_data,     0);
        check({tag, "_o_valid"},    o_valid,    0);
        check({tag, "_o_done"},     o_done,     0);
        check({tag, "_o_overflow"}, o_overflow, 0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b0;
        #1;
        check_outputs_zero("midrst");
        for (int k = cyc; k < MAXC; k++) begin
            exp_v[k] = 1'b0; exp_s[k] = 1'b0; exp_dn[k] = 1'b0;
        end
        active = 1'b0; done_cyc = 0; sent = 0;
        repeat (2) @(posedge clk);
        #1;
        i_rst  = 1'b1;
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("o_valid", o_valid, exp_v[cyc]);
            if (exp_v[cyc])
                check("o_data", o_data, exp_d[cyc]);
            check("o_start", o_start, exp_s[cyc]);
            check("o_done",  o_done,  exp_dn[cyc]);
            if (o_valid) cap_q.push_back(o_data);
        end
    end

    logic [15:0] e1 [4];
    logic [15:0] e5 [4];

    initial begin
        for (int k = 0; k < MAXC; k++) begin
            exp_v[k] = 1'b0; exp_d[k] = '0; exp_s[k] = 1'b0; exp_dn[k] = 1'b0;
        end
        i_rst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_acc = '0;
        i_max_width = '0; i_max_height = '0; i_bias = '0; i_shift = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        i_rst  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // W=H=2, S=8 rounding
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 2, 2, 32'h0, 8);
        drive(1'b0, 1'b1, 32'h100);
        drive(1'b0, 1'b1, 32'h280);
        drive(1'b0, 1'b1, 32'h17F);
        drive(1'b0, 1'b1, 32'h0);
        idle(6);
        e1 = '{16'h0001, 16'h0003, 16'h0001, 16'h0000};
        check("f1_count", cap_q.size(), 4);
        if (cap_q.size() == 4)
            for (int k = 0; k < 4; k++) check($sformatf("f1_pix%0d", k), cap_q[k], e1[k]);
        check("f1_ovf", o_overflow, 0);

        // bias=-1000, S=0, acc=500
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 1, 1, -32'sd1000, 0);
        drive(1'b0, 1'b1, 32'd500);
        idle(6);
        check("f2_count", cap_q.size(), 1);
`ifdef CONV_POSTPROC_RELU_EN
        if (cap_q.size() == 1) check("f2_pix", cap_q[0], 16'h0000);
`else
        if (cap_q.size() == 1) check("f2_pix", cap_q[0], 16'hFE0C);
`endif
        check("f2_ovf", o_overflow, 0);

        // positive saturation
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 1, 1, 32'h0, 0);
        drive(1'b0, 1'b1, 32'd70000);
        idle(6);
`ifdef CONV_POSTPROC_RELU_EN
        if (cap_q.size() == 1) check("f3_pix", cap_q[0], 16'hFFFF);
`else
        if (cap_q.size() == 1) check("f3_pix", cap_q[0], 16'h7FFF);
`endif
        check("f3_count", cap_q.size(), 1);
        check("f3_ovf", o_overflow, 1);

        // negative saturation; overflow must clear on the new start
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 1, 1, 32'h0, 0);
        drive(1'b0, 1'b1, -32'sd40000);
        check("f4_ovf_clr", o_overflow, 0);
        idle(6);
        check("f4_count", cap_q.size(), 1);
`ifdef CONV_POSTPROC_RELU_EN
        if (cap_q.size() == 1) check("f4_pix", cap_q[0], 16'h0000);
        check("f4_ovf", o_overflow, 0);
`else
        if (cap_q.size() == 1) check("f4_pix", cap_q[0], 16'h8000);
        check("f4_ovf", o_overflow, 1);
`endif

        // S=1 rounding of negatives and extreme accumulators
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 4, 1, 32'd5, 1);
        drive(1'b0, 1'b1, -32'sd8);
        drive(1'b0, 1'b1, -32'sd6);
        drive(1'b0, 1'b1, 32'h7FFF_FFFF);
        drive(1'b0, 1'b1, 32'h8000_0000);
        idle(6);
`ifdef CONV_POSTPROC_RELU_EN
        e5 = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
`else
        e5 = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
`endif
        check("f5_count", cap_q.size(), 4);
        if (cap_q.size() == 4)
            for (int k = 0; k < 4; k++) check($sformatf("f5_pix%0d", k), cap_q[k], e5[k]);

        // 6x6 with gaps, extra beats dropped, mid-frame start ignored
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 6, 6, -32'sd123, 3);
        for (int i = 0; i < 80; i++)
            drive(i == 21, (i % 2) == 0, 32'(i * 7919 - 250000), 2, 2, 32'd999, 0);
        idle(6);
        check("f6_count", cap_q.size(), 36);

        // zero width: no pixels, o_done two cycles after start
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 0, 6, 32'h0, 0);
        drive(1'b0, 1'b1, 32'd42);
        idle(5);
        check("f7_count", cap_q.size(), 0);

        // reset mid-frame, then a clean frame
        drive(1'b1, 1'b0, 32'h0, 6, 6, 32'h0, 0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 32'd100000);
        do_reset();
        cap_q.delete();
        drive(1'b1, 1'b0, 32'h0, 3, 2, 32'd10, 2);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 32'(i * 37 - 90));
        idle(8);
        check("f9_count", cap_q.size(), 6);
        check("f9_ovf", o_overflow, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_postproc.md
# conv_postproc

Post-processing stage between the conv2d accumulator output and maxpool2d. It takes a raster stream of signed ACC_WIDTH accumulator sums for one output feature map and adds a per-map bias. It then applies a rounded arithmetic right shift, optional ReLU and saturation to DATA_WIDTH. The result is a framed stream (`o_start`, `o_data`/`o_valid`, `o_done`) of the kind maxpool2d consumes.

## Interface
- `ACC_WIDTH`, 32: signed accumulator width.
- `DATA_WIDTH`, 16: output pixel width.
- `SHIFT_WIDTH`, 5: requantisation shift field width.
- `i_clk` input 1: clock; all logic on rising edge.
- `i_rst` input 1: asynchronous, active-low reset. This is the design's only clock domain.
- `i_start` input 1: one-cycle frame start pulse; honoured only in IDLE.
- `i_max_width` input 9: feature-map width W; latched on accepted `i_start`.
- `i_max_height` input 9: feature-map height H; latched on accepted `i_start`.
- `i_bias` input ACC_WIDTH: signed bias; latched on accepted `i_start`.
- `i_shift` input SHIFT_WIDTH: right-shift amount S; latched on accepted `i_start`.
- `i_acc` input ACC_WIDTH: signed accumulator beat.
- `i_valid` input 1: `i_acc` valid this cycle. There is no backpressure.
- `o_start` output 1: one-cycle pulse exactly one cycle before the first `o_valid` of a frame.
- `o_data` output DATA_WIDTH: result pixel.
- `o_valid` output 1: `o_data` valid.
- `o_done` output 1: one-cycle pulse after the last pixel of the frame.
- `o_overflow` output 1: sticky; set if any pixel in the current frame saturated. Cleared on accepted `i_start`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + `i_start`: latch W, H, bias and S; clear `in_cnt`, `out_cnt` and `o_overflow`; go to RUN.
  - IDLE + `i_start` with W==0 or H==0: go straight to DRAIN. Produces no output; `o_done` follows.
  - RUN: each `i_valid` beat enters the pipeline and increments `in_cnt` (18 bits; N = W*H ≤ 261121). When the beat with `in_cnt` == N-1 is accepted, go to DRAIN.
  - DRAIN: ignore `i_valid`. When `out_cnt` == N and the pipeline is empty, pulse `o_done` and return to IDLE.
- `i_start` outside IDLE is ignored. `i_valid` in IDLE or DRAIN is dropped.
- Arithmetic, per beat:
  - Stage 1: s1 = `i_acc` + bias, ACC_WIDTH+1 bits signed, no wrap.
  - Stage 2: if S>0, s2 = (s1 + (1<<(S-1))) >>> S, i.e. round half up. If S==0, s2 = s1.
  - Stage 3: ReLU/saturate per Configuration.
- `o_start` is generated when the frame's first beat is in stage 2.
- Reset in any state: pipeline is flushed, FSM goes to IDLE, counters clear. The partial frame is lost and `o_done` is not produced.

## Timing
- Reset values: `o_start`=0, `o_data`=0, `o_valid`=0, `o_done`=0, `o_overflow`=0.
- Latency is 3 cycles: a beat accepted in cycle t appears with `o_valid` in cycle t+3.
- Throughput is one pixel per cycle. Output gaps mirror input gaps exactly.
- `o_done` asserts in the cycle after the final `o_valid`. For W or H = 0, it asserts 2 cycles after `i_start`.
- maxpool2d requires a gapless stream, so the upstream source must hold `i_valid` continuously for a frame.

## Configuration
- `CONV_POSTPROC_RELU_EN` defined:
  - s2<0 → 0.
  - s2>2^DATA_WIDTH-1 → all-ones, and `o_overflow` is set.
  - Output is unsigned.
- Not defined:
  - Output is signed two's complement, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Either clamp sets `o_overflow`.
  - maxpool2d must then compare signed.

## Structure
- Shared package `conv_pkg`: ACC_WIDTH, DATA_WIDTH and SHIFT_WIDTH defaults, the 9-bit dimension width, the 18-bit pixel-count width, and the FSM state enum.
- Sub-module `requant_sat`: the 3-stage bias/round/saturate datapath, with a valid shift chain and a per-stage first-beat tag.
- The parent holds the FSM, counters, the `o_done` logic and the sticky overflow flag.

## Test plan
- W=H=2, bias=0, S=8; `i_acc` = 0x100, 0x280, 0x17F, 0x0, continuous → `o_data` 1, 3, 1, 0. `o_start` 1 cycle before the first `o_valid`; `o_done` 1 cycle after the 4th.
- RELU_EN, bias=-1000, S=0, `i_acc`=500 → 0. `i_acc`=70000, bias=0 → 0xFFFF with `o_overflow`=1. Without the macro: 70000 → 0x7FFF, and -40000 → 0x8000.
- W=6, H=6, `i_valid` toggling every other cycle → 36 outputs with the same gaps. Beats after the 36th are dropped. `i_start` mid-frame is ignored.
- W=0, H=6 → no `o_valid`; `o_done` 2 cycles after `i_start`.
- `i_rst` low after 10 beats of a 36-pixel frame → all outputs 0 immediately. A new frame then completes normally with `o_overflow` cleared.
